stack_engine: RTL and testbench
===============================

STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 Parameter: BASE, 16'h3FFF, word address one above the first stack slot; stack grows downward.
REQ-002 Parameter: DEPTH, 64, maximum number of stacked words (1..1024).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  engine can accept a request.
REQ-007 req_op  in  2  request op: 00 push, 01 pop, 10 peek, 11 clear.
REQ-008 req_data  in  16  push operand.
REQ-009 rsp_valid  out  1  response present.
REQ-010 rsp_ready  in  1  consumer accepts the response.
REQ-011 rsp_data  out  16  popped or peeked word; 0 for push, clear and errors.
REQ-012 rsp_err  out  1  overflow or underflow on this request.
REQ-013 mem_addr  out  16  word address to stack memory.
REQ-014 mem_wdata  out  16  write data.
REQ-015 mem_we  out  1  write strobe, one cycle.
REQ-016 mem_re  out  1  read strobe; mem_rdata is valid the following cycle.
REQ-017 mem_rdata  in  16  read data.
REQ-018 sp  out  16  current stack pointer; points at top-of-stack word.
REQ-019 empty  out  1  asserted when depth equals 0.
REQ-020 full  out  1  asserted when depth equals DEPTH.

Function
REQ-021 FSM states: IDLE, WRITE, READ, WAIT, RESP; encoding is free.
REQ-022 req_ready is asserted only in IDLE.
REQ-023 A request is accepted on a cycle where req_valid and req_ready are both high; req_op and req_data are latched on that cycle.
REQ-024 Push with full=0:
- IDLE -> WRITE.
- In WRITE: mem_we=1, mem_addr=sp-1, mem_wdata=latched data; sp<=sp-1.
- WRITE -> RESP with rsp_err=0.
REQ-025 Pop or peek with empty=0:
- IDLE -> READ, with mem_re=1 and mem_addr=sp.
- READ -> WAIT; mem_rdata is captured at the end of WAIT.
- WAIT -> RESP.
- Pop only: sp<=sp+1 on the WAIT->RESP edge. Peek leaves sp unchanged.
REQ-026 Push with full=1, or pop/peek with empty=1:
- IDLE -> RESP directly.
- rsp_err=1, rsp_data=0.
- No memory strobe is issued and sp is unchanged.
REQ-027 Clear: sp<=BASE and IDLE -> RESP; rsp_err=0 and no memory strobe.
REQ-028 In RESP, rsp_valid=1 and rsp_data/rsp_err are held stable until rsp_ready=1; then RESP -> IDLE on that edge.
REQ-029 Latency from acceptance edge to rsp_valid:
- push: 2 cycles.
- pop/peek: 3 cycles.
- error or clear: 1 cycle.
REQ-030 mem_we and mem_re are never asserted together, and neither is asserted outside WRITE or READ.
REQ-031 depth=BASE-sp, treated as unsigned 16-bit; full and empty are combinational from sp.
REQ-032 A req_valid that is high while req_ready is low has no effect; the requester holds the request.
REQ-033 Back-to-back operation: if rsp_ready is high on entering RESP, the next request can be accepted on the cycle after RESP, so a push completes every 3 cycles.

Reset
REQ-034 While rst=1:
- State <= IDLE, sp <= BASE.
- rsp_valid=0, rsp_err=0, rsp_data=0.
- mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
REQ-035 If rst is asserted mid-operation (WRITE, READ, WAIT or RESP), the in-flight request is aborted with no response, and no memory strobe occurs in the cycle rst is high.
REQ-036 req_ready=1 on the first cycle after rst deasserts.

Verification
REQ-037 Push 16'hABCD after reset: mem_we one cycle with mem_addr=16'h3FFE and mem_wdata=16'hABCD; sp=16'h3FFE; rsp_valid 2 cycles after acceptance with rsp_err=0.
REQ-038 Push 16'h1111 then 16'h2222, then pop twice: rsp_data=16'h2222 then 16'h1111; sp returns to 16'h3FFF; empty=1.
REQ-039 Pop with empty=1: rsp_err=1 and rsp_data=0 one cycle after acceptance; no mem_re; sp=16'h3FFF.
REQ-040 Push 64 words, then a 65th push: full=1, 65th rsp_err=1, no mem_we, sp=16'h3FBF; a following peek returns word 64 and sp is unchanged.
REQ-041 Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid and rsp_data stay stable and req_ready stays 0; the response completes on the cycle rsp_ready=1.
REQ-042 Assert rst during WAIT of a pop with sp=16'h3FFD: no rsp_valid, sp=16'h3FFF, and req_ready=1 the cycle after release.

Source files
------------

// File: rtl/stack_engine_if.sv
// stack_engine_if -- request/response handshake plus stack-memory port for
// stack_engine.
//   req_*  : request channel (valid/ready, op, push operand)
//   rsp_*  : response channel (valid/ready, data, error flag)
//   mem_*  : single-port word memory, read data one cycle after mem_re
//   sp/empty/full : stack status
// Modports: slave = the engine, master = the requester / memory side.
interface stack_engine_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic [15:0] sp;
  logic        empty;
  logic        full;

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           mem_addr, mem_wdata, mem_we, mem_re, sp, empty, full
  );

  modport master (
    output req_valid, req_op, req_data, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           mem_addr, mem_wdata, mem_we, mem_re, sp, empty, full
  );
endinterface

// File: rtl/stack_engine.sv
// stack_engine -- hardware stack held in external word memory, growing
// downward from BASE. Ops: 00 push, 01 pop, 10 peek, 11 clear.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : stack_engine_if.slave (request, response, memory, status)
// Parameters:
//   BASE  : word address one above the first stack slot
//   DEPTH : maximum number of stacked words (1..1024)
module stack_engine #(
  parameter logic [15:0] BASE  = 16'h3FFF,
  parameter int          DEPTH = 64
) (
  input  logic           clk,
  input  logic           rst,
  stack_engine_if.slave  bus
);

  localparam logic [15:0] DEPTH_W = DEPTH[15:0];

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [15:0] r_sp;
  logic [1:0]  r_op;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [15:0] r_rsp_data;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_mem_we;
  logic        r_mem_re;

  logic [15:0] w_depth;
  logic        w_empty;
  logic        w_full;

  // Depth wraps as unsigned 16-bit, so a corrupted sp above BASE never
  // reads as empty.
  assign w_depth = BASE - r_sp;
  assign w_empty = (w_depth == 16'd0);
  assign w_full  = (w_depth == DEPTH_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sp        <= BASE;
      r_op        <= OP_PUSH;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= 16'd0;
      r_mem_addr  <= 16'd0;
      r_mem_wdata <= 16'd0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      // Strobes are single-cycle: raised on entry to WRITE/READ only.
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_op        <= bus.req_op;
            r_req_ready <= 1'b0;
            case (bus.req_op)
              OP_PUSH: begin
                if (w_full) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_data  <= 16'd0;
                end else begin
                  r_state     <= S_WRITE;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_sp - 16'd1;
                  r_mem_wdata <= bus.req_data;
                end
              end
              OP_POP, OP_PEEK: begin
                if (w_empty) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_data  <= 16'd0;
                end else begin
                  r_state    <= S_READ;
                  r_mem_re   <= 1'b1;
                  r_mem_addr <= r_sp;
                end
              end
              default: begin
                r_sp        <= BASE;
                r_state     <= S_RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
                r_rsp_data  <= 16'd0;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_sp        <= r_sp - 16'd1;
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_data  <= 16'd0;
        end
        S_READ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Memory read data is valid during WAIT; capture at its end.
          r_rsp_data  <= bus.mem_rdata;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
          if (r_op == OP_POP) begin
            r_sp <= r_sp + 16'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Strobes and rsp_valid are masked by rst so an aborted request cannot
  // touch memory or present a response in the cycle reset is raised.
  assign bus.req_ready = r_req_ready & ~rst;
  assign bus.rsp_valid = r_rsp_valid & ~rst;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we & ~rst;
  assign bus.mem_re    = r_mem_re & ~rst;
  assign bus.sp        = r_sp;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine -- directed bench for stack_engine with a behavioural
// word memory; expected values are hand-computed from the stack behaviour.
module tb_stack_engine;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic clk = 1'b0;
  logic rst;

  stack_engine_if bus ();

  stack_engine #(.BASE(16'h3FFF), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural memory plus strobe monitor.
  logic [15:0] mem [0:65535];
  int          we_cnt   = 0;
  int          re_cnt   = 0;
  int          both_cnt = 0;
  logic [15:0] we_addr  = 16'd0;
  logic [15:0] we_data  = 16'd0;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      we_cnt  <= we_cnt + 1;
      we_addr <= bus.mem_addr;
      we_data <= bus.mem_wdata;
    end
    if (bus.mem_re) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      re_cnt <= re_cnt + 1;
    end
    if (bus.mem_we && bus.mem_re) both_cnt <= both_cnt + 1;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [15:0] got_data;
  logic        got_err;
  int          got_lat;

  // Issue one request; returns response data/err and latency in edges
  // counted from (and including) the acceptance edge. Completes the
  // response handshake only when rsp_ready is already high.
  task automatic req(input logic [1:0] op, input logic [15:0] d);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("req_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    got_lat = 1;
    while (!bus.rsp_valid && got_lat < 20) begin
      @(negedge clk);
      got_lat++;
    end
    if (got_lat >= 20) check("rsp_valid_timeout", 32'd0, 32'd1);
    got_data = bus.rsp_data;
    got_err  = bus.rsp_err;
    if (bus.rsp_ready) @(negedge clk);
  endtask

  int we0, re0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_data  = 16'd0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sp",        32'(bus.sp),        32'h3FFF);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_empty",     32'(bus.empty),     32'd1);
    check("rst_full",      32'(bus.full),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Single push after reset.
    we0 = we_cnt;
    req(OP_PUSH, 16'hABCD);
    check("push_lat",   32'(got_lat),        32'd2);
    check("push_err",   32'(got_err),        32'd0);
    check("push_data",  32'(got_data),       32'd0);
    check("push_we",    32'(we_cnt - we0),   32'd1);
    check("push_addr",  32'(we_addr),        32'h3FFE);
    check("push_wdata", 32'(we_data),        32'hABCD);
    check("push_sp",    32'(bus.sp),         32'h3FFE);

    re0 = re_cnt;
    req(OP_POP, 16'h0);
    check("pop1_lat",  32'(got_lat),      32'd3);
    check("pop1_data", 32'(got_data),     32'hABCD);
    check("pop1_re",   32'(re_cnt - re0), 32'd1);

    // LIFO ordering.
    req(OP_PUSH, 16'h1111);
    req(OP_PUSH, 16'h2222);
    req(OP_POP, 16'h0);
    check("lifo_pop_a", 32'(got_data), 32'h2222);
    check("lifo_sp_a",  32'(bus.sp),   32'h3FFE);
    req(OP_POP, 16'h0);
    check("lifo_pop_b", 32'(got_data), 32'h1111);
    check("lifo_sp_b",  32'(bus.sp),   32'h3FFF);
    check("lifo_empty", 32'(bus.empty), 32'd1);

    // Underflow.
    re0 = re_cnt;
    req(OP_POP, 16'h0);
    check("uflow_err",  32'(got_err),      32'd1);
    check("uflow_data", 32'(got_data),     32'd0);
    check("uflow_lat",  32'(got_lat),      32'd1);
    check("uflow_re",   32'(re_cnt - re0), 32'd0);
    check("uflow_sp",   32'(bus.sp),       32'h3FFF);
    req(OP_PEEK, 16'h0);
    check("peek_empty_err", 32'(got_err), 32'd1);

    // Clear.
    req(OP_PUSH, 16'h5555);
    we0 = we_cnt;
    re0 = re_cnt;
    req(OP_CLEAR, 16'h0);
    check("clr_lat",    32'(got_lat), 32'd1);
    check("clr_err",    32'(got_err), 32'd0);
    check("clr_sp",     32'(bus.sp),  32'h3FFF);
    check("clr_strobe", 32'((we_cnt - we0) + (re_cnt - re0)), 32'd0);

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < 64; i++) req(OP_PUSH, 16'h0100 + 16'(i));
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_sp",   32'(bus.sp),   32'h3FBF);
    we0 = we_cnt;
    req(OP_PUSH, 16'hDEAD);
    check("oflow_err", 32'(got_err),      32'd1);
    check("oflow_lat", 32'(got_lat),      32'd1);
    check("oflow_we",  32'(we_cnt - we0), 32'd0);
    check("oflow_sp",  32'(bus.sp),       32'h3FBF);
    req(OP_PEEK, 16'h0);
    check("peek_data", 32'(got_data), 32'h013F);
    check("peek_lat",  32'(got_lat),  32'd3);
    check("peek_sp",   32'(bus.sp),   32'h3FBF);

    // Response back-pressure.
    bus.rsp_ready = 1'b0;
    req(OP_PEEK, 16'h0);
    check("hold_first", 32'(got_data), 32'h013F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_data",  32'(bus.rsp_data),  32'h013F);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_done_valid", 32'(bus.rsp_valid), 32'd0);
    check("hold_done_ready", 32'(bus.req_ready), 32'd1);

    // Reset during WAIT of a pop.
    req(OP_CLEAR, 16'h0);
    req(OP_PUSH, 16'hAAAA);
    req(OP_PUSH, 16'hBBBB);
    check("abort_pre_sp", 32'(bus.sp), 32'h3FFD);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_POP;
    @(negedge clk);          // acceptance edge passed: READ
    bus.req_valid = 1'b0;
    @(negedge clk);          // WAIT
    rst = 1'b1;
    #1;
    check("abort_re",    32'(bus.mem_re),    32'd0);
    check("abort_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_sp", 32'(bus.sp), 32'h3FFF);
    @(negedge clk);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_no_rsp",    32'(bus.rsp_valid), 32'd0);

    check("we_re_overlap", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
